rvfi_bus_responder: RTL and testbench
=====================================

# rvfi_bus_responder

Parametrised, multi-port memory-bus responder for the formal and simulation harnesses that wrap `Pipeline`. It generalises the free-input bus model from a zero-latency combinational port pair to NUM_PORTS request/response channels. Each channel has an in-order outstanding-request queue, a per-request latency, and a response held stable under backpressure. Read data and latency come from free inputs, driven by `rvformal_rand_reg` in formal and by the bench in simulation.

## Interface
- NUM_PORTS, 2: number of independent channels (port 0 = ibus, port 1 = dbus by convention).
- ADDR_WIDTH, 32: command address width.
- DATA_WIDTH, 32: data width; multiple of 8.
- FIFO_DEPTH, 4: outstanding requests per port; power of two, ≥2.
- MAX_LATENCY, 7: latency clamp; LAT_W = clog2(MAX_LATENCY+1).

Ports; per-port vectors are flattened, with port p in slice p:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cmd_valid  in  NUM_PORTS  command offered.
- cmd_ready  out  NUM_PORTS  command accepted when valid&&ready.
- cmd_address  in  NUM_PORTS*ADDR_WIDTH  command address (not stored; observed by harness only).
- cmd_write  in  NUM_PORTS  1 = write, 0 = read.
- cmd_wdata  in  NUM_PORTS*DATA_WIDTH  write data (ignored; no backing store).
- cmd_wmask  in  NUM_PORTS*DATA_WIDTH/8  write byte mask (ignored).
- rand_delay  in  NUM_PORTS*LAT_W  requested latency, sampled at accept.
- rand_rdata  in  NUM_PORTS*DATA_WIDTH  free read data, sampled on entry to RESP.
- rsp_valid  out  NUM_PORTS  response available.
- rsp_ready  in  NUM_PORTS  response consumed when valid&&ready.
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  response data.
- occupancy  out  NUM_PORTS*clog2(FIFO_DEPTH+1)  entries queued, including the head.

## Operation
- Ports are fully independent. No shared state, no arbitration.
- Per port, the queue holds {write, d}. d = min(rand_delay, MAX_LATENCY), captured at accept.
- cmd_ready = reset && (occupancy != FIFO_DEPTH). It is registered-count based only: a pop in the same cycle does not free a slot for a push.
- Head FSM per port:
  - EMPTY: occupancy 0, rsp_valid=0.
  - WAIT: counter cnt counts down.
  - RESP: rsp_valid=1.
- Head load happens on the edge where an entry becomes head, either by a push into an empty queue or by a pop with occupancy ≥2. On that edge: d==0 → RESP; otherwise → WAIT with cnt=d.
- WAIT: cnt decrements each cycle. When cnt==1, go to RESP on the next edge.
- On every edge entering RESP: rsp_rdata ← write ? 0 : rand_rdata[p].
- RESP: rsp_valid and rsp_rdata are held stable until rsp_valid&&rsp_ready. On that edge, pop. Then go to EMPTY if occupancy was 1, else head-load the next entry.
- Writes produce an acknowledge response with rsp_rdata=0.
- occupancy: +1 on accept, −1 on pop, unchanged on simultaneous accept and pop.

## Timing
- Reset values, all ports: rsp_valid=0, rsp_rdata=0, occupancy=0, FSM=EMPTY, cnt=0, queue pointers 0. cmd_ready=0 while reset=0.
- Reset asserted mid-operation flushes all queues immediately (asynchronous) and drops queued and presented responses. cmd_ready rises in the first cycle after reset deasserts.
- Latency: command accepted at edge T with d, into an empty queue → rsp_valid high in the cycle after edge T+1+d. d=0 gives 1 cycle, d=MAX_LATENCY gives MAX_LATENCY+1 cycles.
- Queued entry: its latency d starts counting from the pop of its predecessor. With d=0 and rsp_ready=1, successive responses issue on consecutive cycles.
- Throughput: one accept and one response per port per cycle.
- rand_delay > MAX_LATENCY is clamped. rand_delay and rand_rdata values outside their sample edges have no effect.
- Full: with occupancy==FIFO_DEPTH, cmd_ready=0 even if a pop occurs that cycle. cmd_valid is ignored.
- Pointers wrap modulo FIFO_DEPTH. Occupancy distinguishes full from empty.

## Test plan
- Reset: hold reset=0 for 3 cycles with cmd_valid=all 1 → cmd_ready=0, rsp_valid=0, occupancy=0. Release → cmd_ready=all 1 next cycle.
- Latency: port 0 read, rand_delay=3, rand_rdata=0xDEADBEEF at the RESP entry edge, rsp_ready=1 → rsp_valid exactly 4 cycles after accept, rsp_rdata=0xDEADBEEF, occupancy returns to 0.
- Clamp and write: port 1 write with rand_delay=15 (LAT_W=3 forces MAX_LATENCY=7; with MAX_LATENCY=4 and LAT_W=3, use 6) → response after MAX_LATENCY+1 cycles, rsp_rdata=0.
- Backpressure/full: push 4 reads with d=0 and rsp_ready=0 → occupancy=4, cmd_ready=0, rsp_rdata stable while rand_rdata toggles. Raise rsp_ready → 4 responses on 4 consecutive cycles, in order. cmd_ready returns the cycle after the first pop.
- Independence and simultaneity: port 0 full and stalled while port 1 does push+pop every cycle → port 1 occupancy constant at 1, port 0 state unaffected.
- Reset mid-flight: 2 entries queued, head in WAIT cnt=2, assert reset → all outputs zero immediately. After release, a new d=0 read responds with fresh rand_rdata, and no stale response appears.

Source files
------------

// File: rtl/rvfi_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rvfi_bus_responder: NUM_PORTS independent in-order bus responders with a   |
// | per-request latency and backpressure-stable responses from free inputs.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rvfi_bus_responder #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_LATENCY = 7,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 1),
  parameter int OCC_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               cmd_valid,
  output logic [NUM_PORTS-1:0]               cmd_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    cmd_address,
  input  logic [NUM_PORTS-1:0]               cmd_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  cmd_wmask,
  input  logic [NUM_PORTS*LAT_W-1:0]         rand_delay,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    rand_rdata,
  output logic [NUM_PORTS-1:0]               rsp_valid,
  input  logic [NUM_PORTS-1:0]               rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rsp_rdata,
  output logic [NUM_PORTS*OCC_W-1:0]         occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] C_FULL    = OCC_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] C_MAX_LAT = LAT_W'(MAX_LATENCY);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Address and write payload exist only for the harness to observe.
  logic w_unused;
  assign w_unused = ^{cmd_address, cmd_wdata, cmd_wmask};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t                r_state, w_state_nxt;
    logic [LAT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [OCC_W-1:0]      r_occ, w_occ_nxt;
    logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr, w_rd_ptr_inc;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                  r_head_write, w_head_write_nxt;
    logic                  r_q_write [FIFO_DEPTH];
    logic [LAT_W-1:0]      r_q_delay [FIFO_DEPTH];
    logic                  w_ready, w_push, w_pop, w_load, w_load_write;
    logic                  w_from_input, w_enter_resp;
    logic [LAT_W-1:0]      w_raw_delay, w_in_delay, w_load_delay;

    assign w_raw_delay = rand_delay[p*LAT_W +: LAT_W];

    if ((2 ** LAT_W) - 1 > MAX_LATENCY) begin : g_clamp
      assign w_in_delay = (w_raw_delay > C_MAX_LAT) ? C_MAX_LAT : w_raw_delay;
    end else begin : g_no_clamp
      assign w_in_delay = w_raw_delay;
    end

    assign w_ready      = reset && (r_occ != C_FULL);
    assign w_push       = cmd_valid[p] && w_ready;
    assign w_pop        = (r_state == ST_RESP) && rsp_ready[p];
    assign w_occ_nxt    = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
    assign w_load       = ((r_state == ST_EMPTY) || w_pop) && (w_occ_nxt != '0);
    // Nothing left behind the popped head: the new head is the command accepted now.
    assign w_from_input = (r_occ == OCC_W'(w_pop));
    assign w_load_write = w_from_input ? cmd_write[p] : r_q_write[w_rd_ptr_inc];
    assign w_load_delay = w_from_input ? w_in_delay   : r_q_delay[w_rd_ptr_inc];

    always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_head_write_nxt = r_head_write;
      w_enter_resp     = 1'b0;
      if (w_load) begin
        w_head_write_nxt = w_load_write;
        if (w_load_delay == '0) begin
          w_state_nxt  = ST_RESP;
          w_cnt_nxt    = '0;
          w_enter_resp = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = w_load_delay;
        end
      end else if (w_pop) begin
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
      end else if (r_state == ST_WAIT) begin
        w_cnt_nxt = r_cnt - LAT_W'(1);
        if (r_cnt == LAT_W'(1)) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      w_rdata_nxt = r_rdata;
      if (w_enter_resp) begin
        w_rdata_nxt = w_head_write_nxt ? '0 : rand_rdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state      <= ST_EMPTY;
        r_cnt        <= '0;
        r_occ        <= '0;
        r_rdata      <= '0;
        r_head_write <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_cnt        <= w_cnt_nxt;
        r_occ        <= w_occ_nxt;
        r_rdata      <= w_rdata_nxt;
        r_head_write <= w_head_write_nxt;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          r_q_write[i] <= 1'b0;
          r_q_delay[i] <= '0;
        end
      end else begin
        if (w_push) begin
          r_q_write[r_wr_ptr] <= cmd_write[p];
          r_q_delay[r_wr_ptr] <= w_in_delay;
          r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= w_rd_ptr_inc;
        end
      end
    end

    assign cmd_ready[p]                            = w_ready;
    assign rsp_valid[p]                            = (r_state == ST_RESP);
    assign rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH]   = r_rdata;
    assign occupancy[p*OCC_W +: OCC_W]             = r_occ;
  end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rvfi_bus_responder: scoreboard bench for the multi-port bus responder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rvfi_bus_responder;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);
  localparam int OW = $clog2(FD + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NP-1:0]     cmd_valid = '0;
  logic [NP-1:0]     cmd_ready;
  logic [NP*AW-1:0]  cmd_address = '0;
  logic [NP-1:0]     cmd_write = '0;
  logic [NP*DW-1:0]  cmd_wdata = '0;
  logic [NP*DW/8-1:0] cmd_wmask = '0;
  logic [NP*LW-1:0]  rand_delay = '0;
  logic [NP*DW-1:0]  rand_rdata = '0;
  logic [NP-1:0]     rsp_valid;
  logic [NP-1:0]     rsp_ready = '0;
  logic [NP*DW-1:0]  rsp_rdata;
  logic [NP*OW-1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [DW-1:0] exp_next [NP];
  logic [DW-1:0] sb0 [$];
  logic [DW-1:0] sb1 [$];

  rvfi_bus_responder #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD), .MAX_LATENCY(ML)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rand_delay(rand_delay), .rand_rdata(rand_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void sb_push(input int p, input logic [DW-1:0] v);
    if (p == 0) sb0.push_back(v); else sb1.push_back(v);
  endfunction
  function automatic logic [DW-1:0] sb_pop(input int p);
    if (p == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction
  function automatic int sb_size(input int p);
    return (p == 0) ? sb0.size() : sb1.size();
  endfunction
  function automatic logic [DW-1:0] sb_front(input int p);
    return (p == 0) ? sb0[0] : sb1[0];
  endfunction
  function automatic logic [DW-1:0] rd(input int p);
    return rsp_rdata[p*DW +: DW];
  endfunction
  function automatic logic [OW-1:0] occ(input int p);
    return occupancy[p*OW +: OW];
  endfunction

  // Pop/compare before push so a same-cycle accept queues behind the head.
  always @(negedge clock) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_valid[p]) begin
          if (sb_size(p) == 0) check("unexp_rsp", rsp_valid[p], 1'b0);
          else if (rsp_ready[p]) check("rsp_data", rd(p), sb_pop(p));
          else check("hold_data", rd(p), sb_front(p));
        end
        if (cmd_valid[p] && cmd_ready[p]) sb_push(p, exp_next[p]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic wr, input int d,
                       input logic [DW-1:0] rr, input logic [DW-1:0] ex);
    cmd_valid[p]              = 1'b1;
    cmd_write[p]              = wr;
    rand_delay[p*LW +: LW]    = LW'(d);
    rand_rdata[p*DW +: DW]    = rr;
    cmd_address[p*AW +: AW]   = $urandom;
    cmd_wdata[p*DW +: DW]     = $urandom;
    exp_next[p]               = ex;
  endtask

  task automatic wait_rsp(input int p, input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rsp_valid[p]) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int p);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (occ(p) == '0 && !rsp_valid[p]) begin
        idle = 1'b1;
        break;
      end
    end
    check("idle", idle, 1'b1);
  endtask

  initial begin
    int c0;
    int lat;
    logic [DW-1:0] k;
    exp_next[0] = '0;
    exp_next[1] = '0;

    // Reset held with commands offered
    cmd_valid = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_rdata", rsp_rdata, 0);
    end
    tick();
    reset     = 1'b1;
    cmd_valid = '0;
    @(negedge clock);
    check("rel_cmd_ready", cmd_ready, 2'b11);

    // Latency d=3; data sampled at RESP entry, not at accept
    tick();
    rsp_ready = 2'b11;
    drive(0, 1'b0, 3, 32'h1111_1111, 32'hDEAD_BEEF);
    @(negedge clock);
    check("acc_rdy", cmd_ready[0], 1'b1);
    c0 = cyc;
    tick();
    cmd_valid[0] = 1'b0;
    rand_rdata[0*DW +: DW] = 32'hDEAD_BEEF;
    wait_rsp(0, c0, lat);
    check("lat_d3", lat, 4);
    @(negedge clock);
    check("lat_occ0", occ(0), 0);
    check("lat_valid0", rsp_valid[0], 1'b0);

    // Clamped write on port 1
    tick();
    drive(1, 1'b1, 6, 32'h1234_5678, 32'h0);
    @(negedge clock);
    check("acc_rdy", cmd_ready[1], 1'b1);
    c0 = cyc;
    tick();
    cmd_valid[1] = 1'b0;
    wait_rsp(1, c0, lat);
    check("lat_clamp", lat, ML + 1);
    wait_idle(1);

    // Backpressure and full on port 0
    k = 32'hC0FF_EE01;
    tick();
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 2), 0, (i == 0) ? 32'hA5A5_0000 : $urandom,
            (i == 0) ? 32'hA5A5_0000 : ((i == 2) ? 32'h0 : k));
      @(negedge clock);
      check("bp_acc_rdy", cmd_ready[0], 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rand_rdata[0*DW +: DW] = $urandom;
      @(negedge clock);
      check("full_occ", occ(0), 4);
      check("full_rdy", cmd_ready[0], 1'b0);
      tick();
    end
    cmd_valid[0] = 1'b0;
    rand_rdata[0*DW +: DW] = k;
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("drain_valid", rsp_valid[0], 1'b1);
      if (i == 0) check("drain_rdy_first", cmd_ready[0], 1'b0);
      if (i == 1) check("drain_rdy_next", cmd_ready[0], 1'b1);
    end
    @(negedge clock);
    check("drain_done_valid", rsp_valid[0], 1'b0);
    check("drain_done_occ", occ(0), 0);

    // Port 0 full and stalled while port 1 streams push+pop
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, i, (i == 0) ? 32'h5EED_0001 : $urandom,
            (i == 0) ? 32'h5EED_0001 : k);
      tick();
    end
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      drive(1, 1'b0, 0, v, v);
      rand_rdata[0*DW +: DW] = $urandom;
      @(negedge clock);
      check("ind_rdy1", cmd_ready[1], 1'b1);
      if (i > 0) begin
        check("ind_occ1", occ(1), 1);
        check("ind_valid1", rsp_valid[1], 1'b1);
      end
      check("ind_occ0", occ(0), 4);
      check("ind_valid0", rsp_valid[0], 1'b1);
      tick();
    end
    cmd_valid[1] = 1'b0;
    rand_rdata[0*DW +: DW] = k;
    rsp_ready[0] = 1'b1;
    wait_idle(0);
    wait_idle(1);

    // Reset mid-flight: p0 two entries with head in WAIT cnt=2, p1 response presented
    tick();
    rsp_ready = 2'b00;
    drive(0, 1'b0, 3, $urandom, 32'hBAD0_0000);
    drive(1, 1'b0, 0, 32'hBAD1_1111, 32'hBAD1_1111);
    tick();
    cmd_valid[1] = 1'b0;
    drive(0, 1'b0, 0, $urandom, 32'hBAD0_0001);
    tick();
    cmd_valid = '0;
    check("mf_occ0", occ(0), 2);
    check("mf_valid1", rsp_valid[1], 1'b1);
    reset = 1'b0;
    #1;
    check("mf_rst_valid", rsp_valid, 0);
    check("mf_rst_occ", occupancy, 0);
    check("mf_rst_rdata", rsp_rdata, 0);
    check("mf_rst_rdy", cmd_ready, 0);
    sb0.delete();
    sb1.delete();
    tick();
    reset     = 1'b1;
    rsp_ready = 2'b11;
    drive(0, 1'b0, 0, 32'hF00D_CAFE, 32'hF00D_CAFE);
    @(negedge clock);
    check("acc_rdy", cmd_ready[0], 1'b1);
    c0 = cyc;
    tick();
    cmd_valid[0] = 1'b0;
    rand_rdata   = '0;
    wait_rsp(0, c0, lat);
    check("post_rst_lat", lat, 1);
    wait_idle(0);
    wait_idle(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("no_stale", rsp_valid, 0);
    end

    check("sb0_empty", sb_size(0), 0);
    check("sb1_empty", sb_size(1), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
